// File: rtl/rv_pipe_ctrl.sv
// Pipeline control for uRV: stall merge, branch kill windows, and an in-order load scoreboard.
// Define RV_PIPE_CTRL_LOAD_BYPASS_EN to let the completing load's rd drop out of the hazard mask.
module rv_pipe_ctrl #(
   parameter int unsigned N_STALL_SRC = 2,
   parameter int unsigned KILL_DEPTH  = 2,
   parameter int unsigned MAX_PENDING = 2,
   localparam int unsigned PW = $clog2(MAX_PENDING + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_STALL_SRC-1:0] stall_req_i,
   input  logic                   d_valid_i,
   input  logic [4:0]             d_rs1_i,
   input  logic [4:0]             d_rs2_i,
   input  logic                   d_use_rs1_i,
   input  logic                   d_use_rs2_i,
   input  logic                   x_load_i,
   input  logic [4:0]             x_rd_i,
   input  logic                   x_bra_i,
   input  logic                   w_load_done_i,
   output logic                   f_stall_o,
   output logic                   x_stall_o,
   output logic                   w_stall_o,
   output logic                   x_bubble_o,
   output logic                   f_kill_o,
   output logic                   x_kill_o,
   output logic [PW-1:0]          pending_o,
   output logic                   err_o
);

`ifdef RV_PIPE_CTRL_LOAD_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic [4:0]    fifo_q [MAX_PENDING];
   logic [4:0]    fifo_d [MAX_PENDING];
   logic [PW-1:0] count_q, count_d;
   logic [PW-1:0] push_idx;
   logic          err_q, err_d;
   logic          busy, full_stall, load_accept, pop_ok, kill_tail, hazard;
   logic [31:0]   pend_mask;

   assign busy        = |stall_req_i;
   // A same-cycle pop frees the slot the new load needs.
   assign full_stall  = x_load_i && (count_q == PW'(MAX_PENDING)) && !w_load_done_i;
   assign x_stall_o   = busy || full_stall;
   assign f_kill_o    = x_bra_i;
   assign x_kill_o    = x_bra_i || kill_tail;
   assign load_accept = x_load_i && !x_stall_o && !x_kill_o;
   assign pop_ok      = w_load_done_i && (count_q != '0);

   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 0; i < MAX_PENDING; i++) begin
         if ((PW'(i) < count_q) && !(BypassEn && (i == 0) && w_load_done_i)) begin
            pend_mask[fifo_q[i]] = 1'b1;
         end
      end
      if (load_accept) begin
         pend_mask[x_rd_i] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

   assign hazard = d_valid_i && !x_kill_o &&
                   ((d_use_rs1_i && pend_mask[d_rs1_i]) || (d_use_rs2_i && pend_mask[d_rs2_i]));
   assign f_stall_o  = x_stall_o || hazard;
   assign x_bubble_o = hazard && !x_stall_o;

   if (N_STALL_SRC > 1) begin : g_w_stall
      assign w_stall_o = stall_req_i[N_STALL_SRC-1];
   end else begin : g_no_w_stall
      assign w_stall_o = 1'b0;
   end

   if (KILL_DEPTH > 1) begin : g_kill
      logic [KILL_DEPTH-1:1] ks_q, ks_d;

      always_comb begin
         ks_d = ks_q;
         if (!x_stall_o) begin
            ks_d[1] = x_bra_i;
            for (int i = 2; i < KILL_DEPTH; i++) begin
               ks_d[i] = ks_q[i-1];
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            ks_q <= '0;
         end else begin
            ks_q <= ks_d;
         end
      end

      assign kill_tail = |ks_q;
   end else begin : g_no_kill
      assign kill_tail = 1'b0;
   end

   // Shift-down FIFO: entry 0 is always the oldest load.
   always_comb begin
      fifo_d   = fifo_q;
      count_d  = count_q;
      err_d    = err_q;
      push_idx = pop_ok ? (count_q - PW'(1)) : count_q;
      if (pop_ok) begin
         for (int unsigned i = 0; i + 1 < MAX_PENDING; i++) begin
            fifo_d[i] = fifo_q[i+1];
         end
      end
      if (load_accept) begin
         for (int unsigned i = 0; i < MAX_PENDING; i++) begin
            if (PW'(i) == push_idx) begin
               fifo_d[i] = x_rd_i;
            end
         end
      end
      case ({load_accept, pop_ok})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      if (w_load_done_i && (count_q == '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < MAX_PENDING; i++) begin
            fifo_q[i] <= '0;
         end
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         fifo_q  <= fifo_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign pending_o = count_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl with N_STALL_SRC=2, KILL_DEPTH=3, MAX_PENDING=2.
// Honours RV_PIPE_CTRL_LOAD_BYPASS_EN for the load-completion release cycle.
module tb_rv_pipe_ctrl;

`ifdef RV_PIPE_CTRL_LOAD_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [1:0] stall_req_i;
   logic       d_valid_i;
   logic [4:0] d_rs1_i, d_rs2_i;
   logic       d_use_rs1_i, d_use_rs2_i;
   logic       x_load_i;
   logic [4:0] x_rd_i;
   logic       x_bra_i;
   logic       w_load_done_i;
   logic       f_stall_o, x_stall_o, w_stall_o, x_bubble_o, f_kill_o, x_kill_o;
   logic [1:0] pending_o;
   logic       err_o;

   int n_tests = 0;
   int n_fail  = 0;

   rv_pipe_ctrl #(
      .N_STALL_SRC(2),
      .KILL_DEPTH (3),
      .MAX_PENDING(2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_req_i  (stall_req_i),
      .d_valid_i    (d_valid_i),
      .d_rs1_i      (d_rs1_i),
      .d_rs2_i      (d_rs2_i),
      .d_use_rs1_i  (d_use_rs1_i),
      .d_use_rs2_i  (d_use_rs2_i),
      .x_load_i     (x_load_i),
      .x_rd_i       (x_rd_i),
      .x_bra_i      (x_bra_i),
      .w_load_done_i(w_load_done_i),
      .f_stall_o    (f_stall_o),
      .x_stall_o    (x_stall_o),
      .w_stall_o    (w_stall_o),
      .x_bubble_o   (x_bubble_o),
      .f_kill_o     (f_kill_o),
      .x_kill_o     (x_kill_o),
      .pending_o    (pending_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      rst_i = 1'b0; stall_req_i = 2'b00; d_valid_i = 1'b0; d_rs1_i = '0; d_rs2_i = '0;
      d_use_rs1_i = 1'b0; d_use_rs2_i = 1'b0; x_load_i = 1'b0; x_rd_i = '0; x_bra_i = 1'b0;
      w_load_done_i = 1'b0;
   endtask

   task automatic do_reset();
      idle(); rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
   endtask

   task automatic test_reset();
      logic [5:0] outs;
      do_reset();
      outs = {f_stall_o, x_stall_o, w_stall_o, x_bubble_o, f_kill_o, x_kill_o};
      n_tests++;
      if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_outs: got %b want 000000", outs); end
      n_tests++;
      if (pending_o !== 2'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      // Issue load x5 while decode already reads x5: visible in the issue cycle.
      x_load_i = 1'b1; x_rd_i = 5'd5; d_valid_i = 1'b1; d_use_rs1_i = 1'b1; d_rs1_i = 5'd5; #1;
      n_tests++;
      if (f_stall_o !== 1'b1 || x_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL raw_issue: got f=%b x=%b want f=1 x=0", f_stall_o, x_stall_o);
      end
      tick(); x_load_i = 1'b0; #1;
      n_tests++;
      if (pending_o !== 2'd1) begin n_fail++; $display("FAIL raw_pend1: got %0d want 1", pending_o); end
      n_tests++;
      if (f_stall_o !== 1'b1 || x_bubble_o !== 1'b1) begin
         n_fail++; $display("FAIL raw_wait: got f=%b b=%b want 1 1", f_stall_o, x_bubble_o);
      end
      tick(); stall_req_i = 2'b01; #1;
      n_tests++;
      if (f_stall_o !== 1'b1 || x_bubble_o !== 1'b0 || x_stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_busy: got f=%b b=%b x=%b want 1 0 1", f_stall_o, x_bubble_o, x_stall_o);
      end
      tick(); stall_req_i = 2'b00; w_load_done_i = 1'b1; #1;
      n_tests++;
      if (f_stall_o !== !Bypass || x_bubble_o !== !Bypass) begin
         n_fail++;
         $display("FAIL raw_done: got f=%b b=%b want %b", f_stall_o, x_bubble_o, !Bypass);
      end
      tick(); w_load_done_i = 1'b0; #1;
      n_tests++;
      if (f_stall_o !== 1'b0 || pending_o !== 2'd0) begin
         n_fail++; $display("FAIL raw_release: got f=%b p=%0d want 0 0", f_stall_o, pending_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      x_load_i = 1'b1; x_rd_i = 5'd1; #1;
      n_tests++;
      if (x_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ld1: got %b want 0", x_stall_o); end
      tick(); x_rd_i = 5'd2; #1;
      n_tests++;
      if (x_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ld2: got %b want 0", x_stall_o); end
      tick(); x_rd_i = 5'd3; #1;
      n_tests++;
      if (x_stall_o !== 1'b1 || pending_o !== 2'd2) begin
         n_fail++; $display("FAIL b2b_full: got x=%b p=%0d want 1 2", x_stall_o, pending_o);
      end
      tick(); #1;
      n_tests++;
      if (x_stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: got %b want 1", x_stall_o); end
      tick(); w_load_done_i = 1'b1; #1;
      n_tests++;
      if (x_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_swap: got %b want 0", x_stall_o); end
      tick(); idle(); #1;
      n_tests++;
      if (pending_o !== 2'd2) begin n_fail++; $display("FAIL b2b_pend: got %0d want 2", pending_o); end
      d_valid_i = 1'b1; d_use_rs2_i = 1'b1; d_rs2_i = 5'd1; #1;
      n_tests++;
      if (f_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_x1_gone: got %b want 0", f_stall_o); end
      d_rs2_i = 5'd3; #1;
      n_tests++;
      if (f_stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_x3_pend: got %b want 1", f_stall_o); end
      idle(); w_load_done_i = 1'b1; tick(); tick(); w_load_done_i = 1'b0; #1;
      n_tests++;
      if (pending_o !== 2'd0 || err_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drain: got p=%0d e=%b want 0 0", pending_o, err_o);
      end
   endtask

   task automatic test_kill();
      logic [2:0] exp_k [4];
      logic [2:0] got;
      do_reset();
      // Plain window: branch cycle plus two more; a load in the window is dropped.
      x_bra_i = 1'b1; #1;
      n_tests++;
      if (f_kill_o !== 1'b1 || x_kill_o !== 1'b1) begin
         n_fail++; $display("FAIL kill_c0: got f=%b x=%b want 1 1", f_kill_o, x_kill_o);
      end
      tick(); x_bra_i = 1'b0; x_load_i = 1'b1; x_rd_i = 5'd9; #1;
      n_tests++;
      if (f_kill_o !== 1'b0 || x_kill_o !== 1'b1) begin
         n_fail++; $display("FAIL kill_c1: got f=%b x=%b want 0 1", f_kill_o, x_kill_o);
      end
      tick(); x_load_i = 1'b0; #1;
      n_tests++;
      if (x_kill_o !== 1'b1 || pending_o !== 2'd0) begin
         n_fail++; $display("FAIL kill_c2: got x=%b p=%0d want 1 0", x_kill_o, pending_o);
      end
      tick(); #1;
      n_tests++;
      if (x_kill_o !== 1'b0) begin n_fail++; $display("FAIL kill_c3: got %b want 0", x_kill_o); end
      // Stalled cycle mid-window stretches it by one: {x_kill, x_stall, w_stall}.
      exp_k[0] = 3'b100; exp_k[1] = 3'b110; exp_k[2] = 3'b111; exp_k[3] = 3'b100;
      x_bra_i = 1'b1; tick(); x_bra_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         stall_req_i = (c == 1) ? 2'b01 : ((c == 2) ? 2'b10 : 2'b00); #1;
         got = {x_kill_o, x_stall_o, w_stall_o};
         n_tests++;
         if (got !== exp_k[c]) begin
            n_fail++; $display("FAIL kill_stretch[%0d]: got %b want %b", c, got, exp_k[c]);
         end
         tick();
      end
      stall_req_i = 2'b00; #1;
      n_tests++;
      if (x_kill_o !== 1'b0) begin n_fail++; $display("FAIL kill_end: got %b want 0", x_kill_o); end
   endtask

   task automatic test_x0();
      do_reset();
      x_load_i = 1'b1; x_rd_i = 5'd0; d_valid_i = 1'b1; d_use_rs1_i = 1'b1; d_rs1_i = 5'd0;
      d_use_rs2_i = 1'b1; d_rs2_i = 5'd0; #1;
      n_tests++;
      if (f_stall_o !== 1'b0) begin n_fail++; $display("FAIL x0_issue: got %b want 0", f_stall_o); end
      tick(); x_load_i = 1'b0; #1;
      n_tests++;
      if (f_stall_o !== 1'b0 || pending_o !== 2'd1) begin
         n_fail++; $display("FAIL x0_pend: got f=%b p=%0d want 0 1", f_stall_o, pending_o);
      end
      idle(); w_load_done_i = 1'b1; tick(); w_load_done_i = 1'b0;
   endtask

   task automatic test_err();
      do_reset();
      w_load_done_i = 1'b1; tick(); w_load_done_i = 1'b0; #1;
      n_tests++;
      if (err_o !== 1'b1 || pending_o !== 2'd0) begin
         n_fail++; $display("FAIL err_set: got e=%b p=%0d want 1 0", err_o, pending_o);
      end
      tick(); tick(); #1;
      n_tests++;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
      do_reset();
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_o); end
   endtask

   task automatic test_kill_hazard();
      logic [2:0] got;
      do_reset();
      x_load_i = 1'b1; x_rd_i = 5'd7; tick();
      x_load_i = 1'b0; d_valid_i = 1'b1; d_use_rs2_i = 1'b1; d_rs2_i = 5'd7; x_bra_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         got = {f_stall_o, x_bubble_o, x_kill_o};
         n_tests++;
         if (got !== 3'b001) begin
            n_fail++; $display("FAIL killhaz[%0d]: got %b want 001", c, got);
         end
         tick(); x_bra_i = 1'b0;
      end
      #1;
      n_tests++;
      if (f_stall_o !== 1'b1 || x_bubble_o !== 1'b1) begin
         n_fail++; $display("FAIL killhaz_back: got f=%b b=%b want 1 1", f_stall_o, x_bubble_o);
      end
      idle(); w_load_done_i = 1'b1; tick(); w_load_done_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      x_load_i = 1'b1; x_rd_i = 5'd4; tick(); x_rd_i = 5'd6; tick(); x_load_i = 1'b0; #1;
      n_tests++;
      if (pending_o !== 2'd2) begin n_fail++; $display("FAIL rstmid_pend: got %0d want 2", pending_o); end
      do_reset();
      d_valid_i = 1'b1; d_use_rs1_i = 1'b1; d_rs1_i = 5'd4; d_use_rs2_i = 1'b1; d_rs2_i = 5'd6; #1;
      n_tests++;
      if (f_stall_o !== 1'b0 || pending_o !== 2'd0) begin
         n_fail++; $display("FAIL rstmid_clear: got f=%b p=%0d want 0 0", f_stall_o, pending_o);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_raw_hazard();
      test_back_to_back();
      test_kill();
      test_x0();
      test_err();
      test_kill_hazard();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
